// File: rtl/inst_sram_resp_pkg.sv
// Shared definitions for the inst_sram responder: default geometry,
// FSM state encoding and the byte-address to word-index mapping.
package inst_sram_resp_pkg;

    localparam int unsigned INST_SRAM_DEPTH = 1024;
    localparam logic [31:0] INST_SRAM_BASE  = 32'hbfc00000;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Word index relative to the base, with 32-bit wrap; addr[1:0] is dropped.
    function automatic logic [29:0] addr_to_word(input logic [31:0] addr,
                                                 input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[31:2];
    endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// inst_sram bus plus the preload port, as seen between the IF stage
// (master) and the on-chip responder (slave).
interface inst_sram_resp_if;

    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        addr_err;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output ld_valid, ld_addr, ld_data,
        input  inst_sram_rdata, addr_err, ld_ready
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  ld_valid, ld_addr, ld_data,
        output inst_sram_rdata, addr_err, ld_ready
    );

endinterface

// File: rtl/inst_sram_resp_bytebank.sv
// 1R1W synchronous word array with per-byte write enables. A read and a
// write to the same word in one cycle return the old contents.
module sram_bytebank #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read register only loads on a read strobe so the word stays stable otherwise.
    always_comb begin
        rdata_d = re ? mem_q[raddr] : rdata_q;
    end

    // Array update and read register; non-blocking ordering gives read-first.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_sram_resp.sv
// Responder for the IF stage's inst_sram port: clears the array after
// reset, then serves CPU reads/byte writes and idle-cycle preloads.
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = INST_SRAM_DEPTH,
    parameter logic [31:0] BASE_ADDR = INST_SRAM_BASE
) (
    input  logic                   clk,
    input  logic                   resetn,
    inst_sram_resp_if.slave        bus,
    output logic                   init_done
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          hit_q, hit_d;
    logic          addr_err_q, addr_err_d;

    logic [29:0]   cpu_word, ld_word;
    logic          cpu_in_range, ld_in_range;
    logic [AW-1:0] cpu_idx, ld_idx;
    logic          cpu_access;

    logic          bk_re;
    logic [AW-1:0] bk_raddr;
    logic [3:0]    bk_we;
    logic [AW-1:0] bk_waddr;
    logic [31:0]   bk_wdata;
    logic [31:0]   bk_rdata;

    // Address decode for both the CPU port and the preload port.
    always_comb begin
        cpu_word     = addr_to_word(bus.inst_sram_addr, BASE_ADDR);
        ld_word      = addr_to_word(bus.ld_addr, BASE_ADDR);
        cpu_in_range = (cpu_word < DEPTH_W);
        ld_in_range  = (ld_word < DEPTH_W);
        cpu_idx      = cpu_word[AW-1:0];
        ld_idx       = ld_word[AW-1:0];
        cpu_access   = (state_q == ST_READY) && bus.inst_sram_en;
    end

    // State, clear counter and response flags; all return to idle on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            clr_idx_q  <= '0;
            hit_q      <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            hit_q      <= hit_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next state: INIT walks every word once, then READY until reset.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        hit_d      = hit_q;
        addr_err_d = addr_err_q;
        if (state_q == ST_INIT) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end
        // hit_q selects the bank word versus zero; both flags hold while en=0.
        if (cpu_access) begin
            hit_d      = cpu_in_range;
            addr_err_d = !cpu_in_range;
        end
    end

    // Outputs: bank port steering (clear > CPU write > preload) and status.
    always_comb begin
        bk_re    = cpu_access && cpu_in_range;
        bk_raddr = cpu_idx;
        bk_we    = 4'b0000;
        bk_waddr = cpu_idx;
        bk_wdata = bus.inst_sram_wdata;
        if (state_q == ST_INIT) begin
            bk_we    = 4'b1111;
            bk_waddr = clr_idx_q;
            bk_wdata = 32'h0;
        end else if (cpu_access) begin
            if (cpu_in_range) begin
                bk_we = bus.inst_sram_wen;
            end
        end else if (bus.ld_valid && ld_in_range) begin
            bk_we    = 4'b1111;
            bk_waddr = ld_idx;
            bk_wdata = bus.ld_data;
        end
        if (!resetn) begin
            bk_we = 4'b0000;
        end
        bus.inst_sram_rdata = hit_q ? bk_rdata : 32'h0;
        bus.addr_err        = addr_err_q;
        bus.ld_ready        = (state_q == ST_READY) && !bus.inst_sram_en;
        init_done           = (state_q == ST_READY);
    end

    sram_bytebank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .re    (bk_re),
        .raddr (bk_raddr),
        .we    (bk_we),
        .waddr (bk_waddr),
        .wdata (bk_wdata),
        .rdata (bk_rdata)
    );

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp with a 16-word array.
module tb_inst_sram_resp;

    localparam int unsigned DEPTH = 16;

    logic clk;
    logic resetn;
    logic init_done;
    int   checks;
    int   errors;

    inst_sram_resp_if bus ();

    inst_sram_resp #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'hbfc00000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .init_done (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bus.inst_sram_en    = en;
        bus.inst_sram_wen   = wen;
        bus.inst_sram_addr  = addr;
        bus.inst_sram_wdata = wdata;
    endtask

    task automatic ld(input logic valid, input logic [31:0] addr, input logic [31:0] data);
        bus.ld_valid = valid;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
    endtask

    task automatic run_init(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == 1) begin
                check({tag, "_first_rdata"}, bus.inst_sram_rdata, 32'h0);
                check({tag, "_first_ldrdy"}, {31'h0, bus.ld_ready}, 32'h0);
            end
            if (i == DEPTH - 1) check({tag, "_done_early"}, {31'h0, init_done}, 32'h0);
            if (i == DEPTH) begin
                check({tag, "_done_on_time"}, {31'h0, init_done}, 32'h1);
                check({tag, "_rdata_held0"}, bus.inst_sram_rdata, 32'h0);
                check({tag, "_err_held0"}, {31'h0, bus.addr_err}, 32'h0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        cpu(1'b0, 4'h0, 32'h0, 32'h0);
        ld(1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (3) tick();
        check("rst_rdata", bus.inst_sram_rdata, 32'h0);
        check("rst_err", {31'h0, bus.addr_err}, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_ld_ready", {31'h0, bus.ld_ready}, 32'h0);

        // 1: clear takes DEPTH cycles; CPU and preload requests ignored meanwhile
        resetn = 1'b1;
        cpu(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        ld(1'b1, 32'hbfc00000, 32'h12345678);
        run_init("init");
        cpu(1'b1, 4'h0, 32'hbfc0003c, 32'h0);
        ld(1'b0, 32'h0, 32'h0);
        tick();
        check("clr_last_word", bus.inst_sram_rdata, 32'h0);
        check("clr_last_err", {31'h0, bus.addr_err}, 32'h0);
        cpu(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        tick();
        check("clr_word0_ld_ignored", bus.inst_sram_rdata, 32'h0);

        // 2: preload then fetch; rdata holds while en=0
        cpu(1'b0, 4'h0, 32'hbfc00000, 32'h0);
        ld(1'b1, 32'hbfc00000, 32'h24080001);
        #1;
        check("ld_ready_idle", {31'h0, bus.ld_ready}, 32'h1);
        tick();
        ld(1'b0, 32'h0, 32'h0);
        cpu(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        tick();
        check("fetch_w0", bus.inst_sram_rdata, 32'h24080001);
        cpu(1'b0, 4'h0, 32'hbfc0003c, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_en0", bus.inst_sram_rdata, 32'h24080001);
        end

        // 3: byte-masked write is read-first, next read sees merged word
        ld(1'b1, 32'hbfc00004, 32'h11223344);
        tick();
        ld(1'b0, 32'h0, 32'h0);
        cpu(1'b1, 4'b0011, 32'hbfc00004, 32'haaaabbbb);
        tick();
        check("wr_read_first", bus.inst_sram_rdata, 32'h11223344);
        cpu(1'b1, 4'h0, 32'hbfc00004, 32'h0);
        tick();
        check("wr_merged", bus.inst_sram_rdata, 32'h1122bbbb);
        cpu(1'b1, 4'h0, 32'hbfc00007, 32'h0);
        tick();
        check("addr_low_ignored", bus.inst_sram_rdata, 32'h1122bbbb);

        // 4: out-of-range below and above; writes out of range do not alias
        cpu(1'b1, 4'h0, 32'hbfbffffc, 32'h0);
        tick();
        check("oor_low_rdata", bus.inst_sram_rdata, 32'h0);
        check("oor_low_err", {31'h0, bus.addr_err}, 32'h1);
        cpu(1'b1, 4'hf, 32'hbfc00040, 32'hdeadbeef);
        tick();
        check("oor_high_wr_rdata", bus.inst_sram_rdata, 32'h0);
        check("oor_high_wr_err", {31'h0, bus.addr_err}, 32'h1);
        cpu(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("oor_err_holds", {31'h0, bus.addr_err}, 32'h1);
        cpu(1'b1, 4'h0, 32'hbfc00040, 32'h0);
        tick();
        check("oor_high_rd_err", {31'h0, bus.addr_err}, 32'h1);
        cpu(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        tick();
        check("oor_no_alias", bus.inst_sram_rdata, 32'h24080001);
        check("oor_err_cleared", {31'h0, bus.addr_err}, 32'h0);

        // 5: preload blocked while CPU active, accepted when idle
        cpu(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        ld(1'b1, 32'hbfc00008, 32'hcafef00d);
        #1;
        check("ld_ready_busy", {31'h0, bus.ld_ready}, 32'h0);
        tick();
        ld(1'b0, 32'h0, 32'h0);
        tick();
        check("ld_blocked_unchanged", bus.inst_sram_rdata, 32'h0);
        cpu(1'b0, 4'h0, 32'h0, 32'h0);
        ld(1'b1, 32'hbfc00008, 32'hcafef00d);
        #1;
        check("ld_ready_free", {31'h0, bus.ld_ready}, 32'h1);
        tick();
        ld(1'b0, 32'h0, 32'h0);
        cpu(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        tick();
        check("ld_accepted", bus.inst_sram_rdata, 32'hcafef00d);

        // 6: reset mid-INIT restarts the clear
        cpu(1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        tick();
        check("rst2_rdata", bus.inst_sram_rdata, 32'h0);
        check("rst2_init_done", {31'h0, init_done}, 32'h0);
        check("rst2_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
        resetn = 1'b1;
        repeat (5) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        run_init("restart");
        cpu(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        tick();
        check("restart_w2_cleared", bus.inst_sram_rdata, 32'h0);
        cpu(1'b1, 4'h0, 32'hbfc00004, 32'h0);
        tick();
        check("restart_w1_cleared", bus.inst_sram_rdata, 32'h0);
        cpu(1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
